// File: rtl/chunk_transfer_pkg.sv
// Shared types, sizing and address helpers for the chunk transfer controller.
package chunk_transfer_pkg;

    localparam int CHUNK_PART   = 128;  // chunk width in bits
    localparam int DATA_SIZE    = 32;   // memory beat width in bits
    localparam int ADDRESS_SIZE = 28;   // byte address width

    // Number of memory beats that make up one chunk.
    function automatic int beats_f(input int chunk_bits, input int beat_bits);
        return chunk_bits / beat_bits;
    endfunction

    // Number of byte-offset bits inside one chunk.
    function automatic int offset_bits_f(input int chunk_bits);
        return $clog2(chunk_bits / 8);
    endfunction

    localparam int BEATS         = beats_f(CHUNK_PART, DATA_SIZE);
    localparam int OFFSET_BITS   = offset_bits_f(CHUNK_PART);
    localparam int BEAT_BYTES    = DATA_SIZE / 8;
    localparam int BEAT_IDX_BITS = $clog2(BEATS);

    typedef logic [ADDRESS_SIZE-1:0] addr_t;
    typedef logic [DATA_SIZE-1:0]    data_t;
    typedef logic [CHUNK_PART-1:0]   line_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        FILL
    } state_t;

    // Clear the in-chunk byte offset so any byte address maps to its chunk start.
    function automatic addr_t chunk_base(input addr_t addr);
        addr_t base;
        base = addr;
        base[OFFSET_BITS-1:0] = '0;
        return base;
    endfunction

    // Byte address of beat k inside the chunk starting at base.
    function automatic addr_t beat_address(input addr_t base, input logic [BEAT_IDX_BITS-1:0] k);
        return base + (addr_t'(k) << $clog2(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/chunk_transfer_controller_if.sv
// Storage-side and memory-side signals of the chunk transfer controller.
interface chunk_transfer_controller_if;
    import chunk_transfer_pkg::*;

    // Storage side
    logic  miss_request;
    addr_t miss_address;
    logic  busy;
    logic  done;
    addr_t save_address;
    line_t save_data;
    logic  save_need_flag;
    line_t new_data;
    addr_t new_address;
    logic  new_data_save;

    // Memory side
    addr_t mem_address;
    data_t mem_write_value;
    logic  mem_write_trigger;
    logic  mem_read_trigger;
    logic  mem_ready;
    data_t mem_read_value;
    logic  mem_read_valid;

    // Controller view
    modport master (
        input  miss_request, miss_address, save_address, save_data, save_need_flag,
        input  mem_ready, mem_read_value, mem_read_valid,
        output busy, done, new_data, new_address, new_data_save,
        output mem_address, mem_write_value, mem_write_trigger, mem_read_trigger
    );

    // Storage + memory view
    modport slave (
        output miss_request, miss_address, save_address, save_data, save_need_flag,
        output mem_ready, mem_read_value, mem_read_valid,
        input  busy, done, new_data, new_address, new_data_save,
        input  mem_address, mem_write_value, mem_write_trigger, mem_read_trigger
    );

endinterface

// File: rtl/chunk_beat_assembler.sv
// Collects in-order read beats into one chunk line. o_line already contains
// the beat arriving this cycle, so the controller can load the line on the
// same edge the last beat lands (o_full).
module chunk_beat_assembler
    import chunk_transfer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_clear,
    input  logic  i_valid,
    input  data_t i_data,
    output line_t o_line,
    output logic  o_full
);

    logic [BEAT_IDX_BITS-1:0] r_count;
    data_t                    r_slice [BEATS];
    logic [BEATS-1:0]         w_hit;

    // Receive counter: restarts on every new transfer.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_valid) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Slice storage: each beat lands in the slot selected by the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BEATS; i++) r_slice[i] <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (w_hit[i]) r_slice[i] <= i_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slice
            assign w_hit[gi] = i_valid && (r_count == BEAT_IDX_BITS'(gi));
            assign o_line[gi*DATA_SIZE +: DATA_SIZE] = w_hit[gi] ? i_data : r_slice[gi];
        end
    endgenerate

    assign o_full = w_hit[BEATS-1];

endmodule

// File: rtl/chunk_transfer_controller.sv
// Miss handler between chunk storage and word-wide memory: writes back a dirty
// victim beat by beat, then fetches the requested chunk and hands it to storage
// as a single line with a one-cycle load strobe.
module chunk_transfer_controller
    import chunk_transfer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    chunk_transfer_controller_if.master bus
);

    typedef logic [BEAT_IDX_BITS-1:0] beat_idx_t;
    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    state_t    r_state;
    addr_t     r_fetch_base;
    addr_t     r_save_base;
    line_t     r_save_shift;
    beat_idx_t r_beat;

    logic      r_busy;
    logic      r_done;
    logic      r_new_data_save;
    line_t     r_new_data;
    addr_t     r_new_address;
    addr_t     r_mem_address;
    data_t     r_mem_write_value;
    logic      r_mem_write_trigger;
    logic      r_mem_read_trigger;

    logic      w_rx_valid;
    logic      w_rx_clear;
    logic      w_line_full;
    line_t     w_line;

    // Responses only count while fetching; stray strobes elsewhere are dropped.
    assign w_rx_valid = bus.mem_read_valid && (r_state == READ);
    assign w_rx_clear = (r_state == IDLE) && bus.miss_request;

    chunk_beat_assembler u_assembler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_rx_clear),
        .i_valid (w_rx_valid),
        .i_data  (bus.mem_read_value),
        .o_line  (w_line),
        .o_full  (w_line_full)
    );

    // Transfer FSM with all outputs registered; the write-back data is kept in a
    // shift register so the next beat is always the low word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= IDLE;
            r_fetch_base        <= '0;
            r_save_base         <= '0;
            r_save_shift        <= '0;
            r_beat              <= '0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
            r_new_data_save     <= 1'b0;
            r_new_data          <= '0;
            r_new_address       <= '0;
            r_mem_address       <= '0;
            r_mem_write_value   <= '0;
            r_mem_write_trigger <= 1'b0;
            r_mem_read_trigger  <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_new_data_save <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.miss_request) begin
                        r_fetch_base <= chunk_base(bus.miss_address);
                        r_save_base  <= chunk_base(bus.save_address);
                        r_save_shift <= bus.save_data >> DATA_SIZE;
                        r_beat       <= '0;
                        r_busy       <= 1'b1;
                        if (bus.save_need_flag) begin
                            r_state             <= WRITE;
                            r_mem_write_trigger <= 1'b1;
                            r_mem_address       <= chunk_base(bus.save_address);
                            r_mem_write_value   <= bus.save_data[DATA_SIZE-1:0];
                        end else begin
                            r_state            <= READ;
                            r_mem_read_trigger <= 1'b1;
                            r_mem_address      <= chunk_base(bus.miss_address);
                        end
                    end
                end

                WRITE: begin
                    if (bus.mem_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state             <= READ;
                            r_beat              <= '0;
                            r_mem_write_trigger <= 1'b0;
                            r_mem_read_trigger  <= 1'b1;
                            r_mem_address       <= r_fetch_base;
                        end else begin
                            r_beat            <= r_beat + 1'b1;
                            r_mem_address     <= beat_address(r_save_base, r_beat + 1'b1);
                            r_mem_write_value <= r_save_shift[DATA_SIZE-1:0];
                            r_save_shift      <= r_save_shift >> DATA_SIZE;
                        end
                    end
                end

                READ: begin
                    if (r_mem_read_trigger && bus.mem_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_mem_read_trigger <= 1'b0;
                        end else begin
                            r_beat        <= r_beat + 1'b1;
                            r_mem_address <= beat_address(r_fetch_base, r_beat + 1'b1);
                        end
                    end
                    if (w_line_full) begin
                        r_state         <= FILL;
                        r_new_data      <= w_line;
                        r_new_address   <= r_fetch_base;
                        r_new_data_save <= 1'b1;
                        r_done          <= 1'b1;
                    end
                end

                FILL: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy              = r_busy;
    assign bus.done              = r_done;
    assign bus.new_data_save     = r_new_data_save;
    assign bus.new_data          = r_new_data;
    assign bus.new_address       = r_new_address;
    assign bus.mem_address       = r_mem_address;
    assign bus.mem_write_value   = r_mem_write_value;
    assign bus.mem_write_trigger = r_mem_write_trigger;
    assign bus.mem_read_trigger  = r_mem_read_trigger;

endmodule
